// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//   Pipeline hazard controller for a 5-stage in-order core. It covers:
//     - Load-use interlock: one bubble into ID/EX while IF and ID hold.
//       Forwarding covers every other RAW case.
//     - Taken branch/jump resolved in EX: flush IF/ID and ID/EX. This also
//       cancels any load-use stall or mul/div start in that cycle.
//     - Optional multi-cycle mul/div interlock (RUN / MD_BUSY FSM). The
//       front end and EX hold while the unit is busy, and EX/MEM gets
//       bubbles until md_done_i is seen.
//   Priority: flush > mul/div stall > load-use.
//
// Configuration macro:
//   HAZARD_MULDIV_EN  - when defined, the mul/div interlock is built.
//                       When undefined, ex_md_start_i and md_done_i are
//                       ignored, state_o stays 0, and stall_ex_o and
//                       bubble_mem_o are tied to 0.
//
// Ports:
//   clk, rst_n                     clock (rising edge), async active-low reset
//   id_sel_rs1_i, id_sel_rs2_i     source register pointers of the ID instr
//   id_uses_rs1_i, id_uses_rs2_i   ID instr actually reads rs1 / rs2
//   ex_sel_rd_i                    destination pointer of the EX instr
//   ex_is_load_i, ex_reg_write_i   EX instr is a load / writes rd
//   ex_branch_taken_i              taken control transfer resolved in EX
//   ex_md_start_i, md_done_i       mul/div issue in EX / result valid
//   stall_if_o, stall_id_o,
//   stall_ex_o                     hold PC, IF/ID, ID/EX
//   bubble_ex_o, bubble_mem_o      insert NOP into ID/EX, EX/MEM
//   flush_if_id_o, flush_id_ex_o   squash younger instructions
//   state_o                        FSM state (RUN=0, MD_BUSY=1)
//   stall_cnt_o                    saturating count of cycles with stall_id_o=1
//
// Handshake note: all stall, bubble and flush outputs are combinational
// level signals. They are valid for the current cycle only, and the
// pipeline registers act on them at the next rising clk edge.
// ---------------------------------------------------------------------------
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_sel_rs1_i,
  input  logic [4:0]       id_sel_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       ex_sel_rd_i,
  input  logic             ex_is_load_i,
  input  logic             ex_reg_write_i,
  input  logic             ex_branch_taken_i,
  input  logic             ex_md_start_i,
  input  logic             md_done_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_ex_o,
  output logic             bubble_ex_o,
  output logic             bubble_mem_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1
  } state_t;

  state_t state;
  logic   load_use;
  logic   md_stall;
  logic   lu_stall;
  logic   flush;

  // x0 never creates a hazard, because writes to it are discarded.
  assign load_use = ex_is_load_i & ex_reg_write_i & (ex_sel_rd_i != 5'd0) &
                    ((id_uses_rs1_i & (id_sel_rs1_i == ex_sel_rd_i)) |
                     (id_uses_rs2_i & (id_sel_rs2_i == ex_sel_rd_i)));

  // Outputs are qualified with rst_n. This makes every stall drop as soon
  // as reset asserts, even while inputs are still requesting one.
  assign flush = rst_n & ex_branch_taken_i;

`ifdef HAZARD_MULDIV_EN
  // Stall during the start cycle and on every busy cycle until done. In
  // the done cycle the stall releases so the result can advance.
  assign md_stall = rst_n & ~ex_branch_taken_i &
                    (((state == RUN) & ex_md_start_i) |
                     ((state == MD_BUSY) & ~md_done_i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (ex_md_start_i && !ex_branch_taken_i) state <= MD_BUSY;
        MD_BUSY: if (md_done_i) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end
`else
  logic unused_md;
  assign unused_md = ex_md_start_i ^ md_done_i;
  assign md_stall  = 1'b0;
  assign state     = RUN;
`endif

  assign lu_stall = rst_n & (state == RUN) & load_use &
                    ~ex_branch_taken_i & ~md_stall;

  assign stall_if_o    = md_stall | lu_stall;
  assign stall_id_o    = md_stall | lu_stall;
  assign stall_ex_o    = md_stall;
  assign bubble_ex_o   = lu_stall;
  assign bubble_mem_o  = md_stall;
  assign flush_if_id_o = flush;
  assign flush_id_ex_o = flush;
  assign state_o       = state;

  // Saturating stall-cycle counter. It holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (stall_id_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] id_sel_rs1_i, id_sel_rs2_i, ex_sel_rd_i;
  logic id_uses_rs1_i, id_uses_rs2_i, ex_is_load_i, ex_reg_write_i;
  logic ex_branch_taken_i, ex_md_start_i, md_done_i;
  logic stall_if_o, stall_id_o, stall_ex_o, bubble_ex_o, bubble_mem_o;
  logic flush_if_id_o, flush_id_ex_o;
  logic [1:0] state_o;
  logic [15:0] stall_cnt_o;
  logic s_stall_if, s_stall_id, s_stall_ex, s_bubble_ex, s_bubble_mem;
  logic s_flush_if_id, s_flush_id_ex;
  logic [1:0] s_state;
  logic [3:0] s_cnt;

  hazard_unit #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_sel_rs1_i(id_sel_rs1_i), .id_sel_rs2_i(id_sel_rs2_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .ex_sel_rd_i(ex_sel_rd_i), .ex_is_load_i(ex_is_load_i),
    .ex_reg_write_i(ex_reg_write_i), .ex_branch_taken_i(ex_branch_taken_i),
    .ex_md_start_i(ex_md_start_i), .md_done_i(md_done_i),
    .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .stall_ex_o(stall_ex_o),
    .bubble_ex_o(bubble_ex_o), .bubble_mem_o(bubble_mem_o),
    .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
    .state_o(state_o), .stall_cnt_o(stall_cnt_o)
  );

  // Narrow-counter instance sharing the same stimulus (saturation check).
  hazard_unit #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .id_sel_rs1_i(id_sel_rs1_i), .id_sel_rs2_i(id_sel_rs2_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .ex_sel_rd_i(ex_sel_rd_i), .ex_is_load_i(ex_is_load_i),
    .ex_reg_write_i(ex_reg_write_i), .ex_branch_taken_i(ex_branch_taken_i),
    .ex_md_start_i(ex_md_start_i), .md_done_i(md_done_i),
    .stall_if_o(s_stall_if), .stall_id_o(s_stall_id), .stall_ex_o(s_stall_ex),
    .bubble_ex_o(s_bubble_ex), .bubble_mem_o(s_bubble_mem),
    .flush_if_id_o(s_flush_if_id), .flush_id_ex_o(s_flush_id_ex),
    .state_o(s_state), .stall_cnt_o(s_cnt)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clr_inputs();
    id_sel_rs1_i = 5'd0; id_sel_rs2_i = 5'd0; ex_sel_rd_i = 5'd0;
    id_uses_rs1_i = 1'b0; id_uses_rs2_i = 1'b0;
    ex_is_load_i = 1'b0; ex_reg_write_i = 1'b0;
    ex_branch_taken_i = 1'b0; ex_md_start_i = 1'b0; md_done_i = 1'b0;
  endtask

  task automatic drive_load_use(input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic u1, input logic u2);
    ex_is_load_i = 1'b1; ex_reg_write_i = 1'b1; ex_sel_rd_i = rd;
    id_sel_rs1_i = rs1; id_sel_rs2_i = rs2;
    id_uses_rs1_i = u1; id_uses_rs2_i = u2;
  endtask

  task automatic reset_pulse();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    clr_inputs();
    #12;
    check("reset_state", {30'd0, state_o}, 32'd0);
    check("reset_cnt", {16'd0, stall_cnt_o}, 32'd0);
    check("reset_stall_id", {31'd0, stall_id_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Load-use on rs1: one stall/bubble cycle.
    @(negedge clk); drive_load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    #1;
    check("lu_stall_if", {31'd0, stall_if_o}, 32'd1);
    check("lu_stall_id", {31'd0, stall_id_o}, 32'd1);
    check("lu_bubble_ex", {31'd0, bubble_ex_o}, 32'd1);
    check("lu_stall_ex", {31'd0, stall_ex_o}, 32'd0);
    check("lu_flush", {31'd0, flush_if_id_o}, 32'd0);
    @(posedge clk); #1;
    check("lu_cnt", {16'd0, stall_cnt_o}, 32'd1);
    @(negedge clk); clr_inputs(); #1;
    check("lu_release", {31'd0, stall_id_o}, 32'd0);

    // Load-use on rs2.
    @(negedge clk); drive_load_use(5'd9, 5'd1, 5'd9, 1'b0, 1'b1); #1;
    check("lu_rs2_bubble", {31'd0, bubble_ex_o}, 32'd1);
    @(posedge clk); #1;
    check("lu_rs2_cnt", {16'd0, stall_cnt_o}, 32'd2);

    // Matching rs2 that is not read, non-load writer: no stall.
    @(negedge clk); drive_load_use(5'd7, 5'd1, 5'd7, 1'b1, 1'b0); #1;
    check("unused_rs2", {31'd0, stall_id_o}, 32'd0);
    @(negedge clk); drive_load_use(5'd3, 5'd3, 5'd3, 1'b1, 1'b1); ex_is_load_i = 1'b0; #1;
    check("not_load", {31'd0, stall_id_o}, 32'd0);

    // x0 never hazards.
    @(negedge clk); drive_load_use(5'd0, 5'd0, 5'd0, 1'b1, 1'b1); #1;
    check("x0_stall", {31'd0, stall_id_o}, 32'd0);
    check("x0_bubble", {31'd0, bubble_ex_o}, 32'd0);

    // Load-use with a taken branch: flush wins.
    @(negedge clk); drive_load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0); ex_branch_taken_i = 1'b1; #1;
    check("br_flush_if_id", {31'd0, flush_if_id_o}, 32'd1);
    check("br_flush_id_ex", {31'd0, flush_id_ex_o}, 32'd1);
    check("br_stall_id", {31'd0, stall_id_o}, 32'd0);
    check("br_bubble_ex", {31'd0, bubble_ex_o}, 32'd0);
    @(posedge clk); #1;
    check("br_cnt", {16'd0, stall_cnt_o}, 32'd2);
    @(negedge clk); clr_inputs();

`ifdef HAZARD_MULDIV_EN
    reset_pulse();
    // md start, done arrives 4 cycles later: 4 stall cycles.
    @(negedge clk); ex_md_start_i = 1'b1; #1;
    check("md_start_stall_ex", {31'd0, stall_ex_o}, 32'd1);
    check("md_start_bubble_mem", {31'd0, bubble_mem_o}, 32'd1);
    check("md_start_stall_if", {31'd0, stall_if_o}, 32'd1);
    check("md_start_bubble_ex", {31'd0, bubble_ex_o}, 32'd0);
    check("md_start_state", {30'd0, state_o}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); ex_md_start_i = 1'b0; #1;
      check("md_busy_state", {30'd0, state_o}, 32'd1);
      check("md_busy_stall_id", {31'd0, stall_id_o}, 32'd1);
    end
    @(negedge clk); md_done_i = 1'b1; #1;
    check("md_done_stall_ex", {31'd0, stall_ex_o}, 32'd0);
    check("md_done_stall_id", {31'd0, stall_id_o}, 32'd0);
    @(negedge clk); md_done_i = 1'b0; #1;
    check("md_back_run", {30'd0, state_o}, 32'd0);
    check("md_cnt", {16'd0, stall_cnt_o}, 32'd4);
    // md_done in RUN is ignored.
    @(negedge clk); md_done_i = 1'b1;
    @(posedge clk); #1;
    check("done_in_run", {30'd0, state_o}, 32'd0);
    // md start with taken branch is suppressed.
    @(negedge clk); md_done_i = 1'b0; ex_md_start_i = 1'b1; ex_branch_taken_i = 1'b1; #1;
    check("md_br_stall_ex", {31'd0, stall_ex_o}, 32'd0);
    check("md_br_flush", {31'd0, flush_id_ex_o}, 32'd1);
    @(negedge clk); clr_inputs(); #1;
    check("md_br_state", {30'd0, state_o}, 32'd0);
    // Reset asserted while MD_BUSY, without a clock edge.
    @(negedge clk); ex_md_start_i = 1'b1;
    @(negedge clk); ex_md_start_i = 1'b0; #1;
    check("pre_rst_state", {30'd0, state_o}, 32'd1);
    #2 rst_n = 1'b0; #1;
    check("rst_busy_state", {30'd0, state_o}, 32'd0);
    check("rst_busy_stall_ex", {31'd0, stall_ex_o}, 32'd0);
    check("rst_busy_stall_id", {31'd0, stall_id_o}, 32'd0);
    check("rst_busy_cnt", {16'd0, stall_cnt_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_state", {30'd0, state_o}, 32'd0);
`else
    // Without the mul/div interlock, the md inputs have no effect.
    @(negedge clk); ex_md_start_i = 1'b1; #1;
    check("nomd_stall_ex", {31'd0, stall_ex_o}, 32'd0);
    check("nomd_stall_id", {31'd0, stall_id_o}, 32'd0);
    check("nomd_bubble_mem", {31'd0, bubble_mem_o}, 32'd0);
    @(posedge clk); #1;
    check("nomd_state", {30'd0, state_o}, 32'd0);
    @(negedge clk); clr_inputs();
    // Asynchronous reset clears the counter without a clock edge.
    #2 rst_n = 1'b0; #1;
    check("rst_async_cnt", {16'd0, stall_cnt_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
`endif

    // Saturation: 20 stalled cycles.
    reset_pulse();
    @(negedge clk); drive_load_use(5'd12, 5'd12, 5'd0, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk); clr_inputs(); #1;
    check("sat_cnt4", {28'd0, s_cnt}, 32'd15);
    check("sat_cnt16", {16'd0, stall_cnt_o}, 32'd20);
    @(posedge clk); #1;
    check("sat_hold", {28'd0, s_cnt}, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
